// File: rtl/jmb_scanline_window_buffer_pkg.sv
// Shared definitions for the scanline window buffer and its consumers:
// default pixel width, 3x3 window geometry, element indices and a pack/unpack helper macro.
`ifndef JMB_SCANLINE_WINDOW_BUFFER_PKG_SV
`define JMB_SCANLINE_WINDOW_BUFFER_PKG_SV

// Selects element k of a packed window whose elements are dw bits wide.
`define JMB_WIN_ELEM(win, k, dw) win[(dw)*(k) +: (dw)]

package jmb_scanline_window_buffer_pkg;
  localparam int JMB_DATA_WIDTH = 8;
  localparam int WIN_COLS       = 3;
  localparam int WIN_ROWS       = 3;
  localparam int WIN_ELEMS      = WIN_COLS * WIN_ROWS;

  // Element index k = 3*row + col; row 0 is the oldest line, col 0 the leftmost.
  localparam int TL = 0;
  localparam int TM = 1;
  localparam int TR = 2;
  localparam int ML = 3;
  localparam int MM = 4;
  localparam int MR = 5;
  localparam int BL = 6;
  localparam int BM = 7;
  localparam int BR = 8;
endpackage

`endif

// File: rtl/jmb_line_buffer.sv
// Single-port line store: asynchronous read, synchronous write at the same address.
module jmb_line_buffer
  import jmb_scanline_window_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = JMB_DATA_WIDTH,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Read returns the old word during a write cycle, which the window builder relies on.
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/jmb_scanline_window_buffer.sv
// Builds a sliding 3x3 window over a raster pixel stream using two line buffers;
// emits one window per interior pixel with its centre coordinates and an end-of-frame pulse.
module jmb_scanline_window_buffer
  import jmb_scanline_window_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = JMB_DATA_WIDTH,
  parameter int MAX_WIDTH  = 1024,
  parameter int DIM_WIDTH  = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             pixel_in,
  input  logic                              pixel_wr,
  input  logic                              enable,
  input  logic [DIM_WIDTH-1:0]              width,
  input  logic [DIM_WIDTH-1:0]              height,
  output logic [WIN_ELEMS*DATA_WIDTH-1:0]   window_out,
  output logic                              window_valid,
  output logic [DIM_WIDTH-1:0]              center_x,
  output logic [DIM_WIDTH-1:0]              center_y,
  output logic                              frame_done,
  output logic                              cfg_error
);

  localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  logic [DIM_WIDTH-1:0]            r_x;
  logic [DIM_WIDTH-1:0]            r_y;
  logic [WIN_ELEMS*DATA_WIDTH-1:0] r_win;
  logic                            r_valid;
  logic [DIM_WIDTH-1:0]            r_cx;
  logic [DIM_WIDTH-1:0]            r_cy;
  logic                            r_frame_done;

  logic                            w_accept;
  logic                            w_last_col;
  logic                            w_last_row;
  logic                            w_interior;
  logic [ADDR_W-1:0]               w_addr;
  logic [DATA_WIDTH-1:0]           w_lb0_rd;
  logic [DATA_WIDTH-1:0]           w_lb1_rd;
  logic [DATA_WIDTH-1:0]           w_col [WIN_ROWS];

  assign cfg_error = (width < DIM_WIDTH'(3)) || (width > DIM_WIDTH'(MAX_WIDTH)) ||
                     (height < DIM_WIDTH'(3));

  assign w_accept   = pixel_wr & enable & ~cfg_error;
  assign w_last_col = (r_x == width - DIM_WIDTH'(1));
  assign w_last_row = (r_y == height - DIM_WIDTH'(1));
  assign w_interior = (r_x >= DIM_WIDTH'(2)) && (r_y >= DIM_WIDTH'(2));
  assign w_addr     = r_x[ADDR_W-1:0];

  // lb0 holds row y-1, lb1 row y-2; on accept each row shifts up one buffer.
  jmb_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_lb0 (
    .clock   (clock),
    .i_we    (w_accept),
    .i_addr  (w_addr),
    .i_wdata (pixel_in),
    .o_rdata (w_lb0_rd)
  );

  jmb_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_lb1 (
    .clock   (clock),
    .i_we    (w_accept),
    .i_addr  (w_addr),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  assign w_col[0] = w_lb1_rd;
  assign w_col[1] = w_lb0_rd;
  assign w_col[2] = pixel_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_win        <= '0;
      r_valid      <= 1'b0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= w_accept & w_interior;
      r_frame_done <= w_accept & w_last_col & w_last_row;
      if (w_accept) begin
        r_cx <= r_x - DIM_WIDTH'(1);
        r_cy <= r_y - DIM_WIDTH'(1);
        for (int r = 0; r < WIN_ROWS; r++) begin
          r_win[DATA_WIDTH*(WIN_COLS*r)   +: DATA_WIDTH] <= r_win[DATA_WIDTH*(WIN_COLS*r+1) +: DATA_WIDTH];
          r_win[DATA_WIDTH*(WIN_COLS*r+1) +: DATA_WIDTH] <= r_win[DATA_WIDTH*(WIN_COLS*r+2) +: DATA_WIDTH];
          r_win[DATA_WIDTH*(WIN_COLS*r+2) +: DATA_WIDTH] <= w_col[r];
        end
        if (w_last_col) begin
          r_x <= '0;
          r_y <= w_last_row ? '0 : r_y + DIM_WIDTH'(1);
        end else begin
          r_x <= r_x + DIM_WIDTH'(1);
        end
      end
    end
  end

  assign window_out   = r_win;
  assign window_valid = r_valid;
  assign center_x     = r_cx;
  assign center_y     = r_cy;
  assign frame_done   = r_frame_done;

endmodule
